// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared command indices, timing defaults and state encodings for the game front end
package game_pkg;

  localparam int CMD_CONTINUE = 0;
  localparam int CMD_PAUSE    = 1;
  localparam int CMD_ESC      = 2;
  localparam int CMD_RESTART  = 3;
  localparam int CMD_NUM      = 4;

  localparam int DEF_DEBOUNCE_CYCLES = 2000000;
  localparam int DEF_LOCKOUT_CYCLES  = 4;
  localparam int DEF_CNT_W           = 21;

  typedef enum logic [1:0] {
    CHOOSE  = 2'b00,
    PLAYING = 2'b01,
    PAUSE   = 2'b10,
    OVER    = 2'b11
  } game_state_e;

  // Collapse the FSM's one-hot enables into the shared state code; only meaningful when one-hot.
  function automatic game_state_e en_to_state(input logic choose_en, input logic playing_en,
                                              input logic pause_en, input logic over_en);
    game_state_e st;
    st = CHOOSE;
    if (playing_en) st = PLAYING;
    if (pause_en)   st = PAUSE;
    if (over_en)    st = OVER;
    if (choose_en)  st = CHOOSE;
    return st;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser, stable-count debounce and rising-edge press detect
module btn_debounce
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_db;
  logic             r_db_prev;
  logic [CNT_W-1:0] r_cnt;

  // Bring the raw pin into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after it has differed from the debounced level for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_db  <= 1'b0;
      r_cnt <= '0;
    end else if (r_sync2 == r_db) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      r_db  <= r_sync2;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Remember last debounced level so a held button yields a single press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_db_prev <= 1'b0;
    else     r_db_prev <= r_db;
  end

  assign o_press = r_db & ~r_db_prev;

endmodule

// File: rtl/game_cmd_gen.sv
// rtl/game_cmd_gen.sv - button-to-command front end for the game FSM; GAME_CMD_CNT_EN adds cmd_cnt
module game_cmd_gen
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LOCKOUT_CYCLES  = DEF_LOCKOUT_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_confirm,
  input  logic       btn_pause,
  input  logic       choose_en,
  input  logic       playing_en,
  input  logic       pause_en,
  input  logic       over_en,
  output logic       cmd_continue,
  output logic       cmd_pause,
  output logic       cmd_esc_pause,
  output logic       cmd_restart
`ifdef GAME_CMD_CNT_EN
  ,
  output logic [7:0] cmd_cnt
`endif
);

  logic               w_press_confirm;
  logic               w_press_pause;
  logic               w_en_ok;
  game_state_e        w_state;
  logic [CMD_NUM-1:0] w_cmd_next;
  logic               w_issue;
  logic [CMD_NUM-1:0] r_cmd;
  logic [CNT_W-1:0]   r_lock;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_confirm (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn_confirm),
    .o_press (w_press_confirm)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_pause (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn_pause),
    .o_press (w_press_pause)
  );

  assign w_en_ok = $onehot({choose_en, playing_en, pause_en, over_en});

  // Decode a press against the current state; confirm pre-empts pause, and lockout or a bad enable set drops everything.
  always_comb begin
    w_cmd_next = '0;
    w_state    = en_to_state(choose_en, playing_en, pause_en, over_en);
    if (w_en_ok && (r_lock == '0)) begin
      if (w_press_confirm) begin
        case (w_state)
          CHOOSE:  w_cmd_next[CMD_CONTINUE] = 1'b1;
          PAUSE:   w_cmd_next[CMD_ESC]      = 1'b1;
          OVER:    w_cmd_next[CMD_RESTART]  = 1'b1;
          default: ;
        endcase
      end else if (w_press_pause) begin
        case (w_state)
          PLAYING: w_cmd_next[CMD_PAUSE]    = 1'b1;
          PAUSE:   w_cmd_next[CMD_ESC]      = 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign w_issue = |w_cmd_next;

  // Register the command so each pulse is a clean single cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cmd <= '0;
    else     r_cmd <= w_cmd_next;
  end

  // Hold off new presses until the FSM has settled into the state the last command selected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                r_lock <= '0;
    else if (w_issue)       r_lock <= CNT_W'(LOCKOUT_CYCLES);
    else if (r_lock != '0)  r_lock <= r_lock - 1'b1;
  end

  assign cmd_continue  = r_cmd[CMD_CONTINUE];
  assign cmd_pause     = r_cmd[CMD_PAUSE];
  assign cmd_esc_pause = r_cmd[CMD_ESC];
  assign cmd_restart   = r_cmd[CMD_RESTART];

`ifdef GAME_CMD_CNT_EN
  logic [7:0] r_cmd_cnt;

  // Count issued commands for the debug display; wraps naturally at 8 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_cmd_cnt <= '0;
    else if (w_issue) r_cmd_cnt <= r_cmd_cnt + 8'd1;
  end

  assign cmd_cnt = r_cmd_cnt;
`endif

endmodule

// File: tb/tb_game_cmd_gen.sv
// tb/tb_game_cmd_gen.sv - directed self-checking bench for game_cmd_gen with short debounce and lockout
module tb_game_cmd_gen;

  localparam int NO = 1000;

  logic clk = 1'b0;
  logic rst;
  logic btn_confirm, btn_pause;
  logic choose_en, playing_en, pause_en, over_en;
  logic cmd_continue, cmd_pause, cmd_esc_pause, cmd_restart;
`ifdef GAME_CMD_CNT_EN
  logic [7:0] cmd_cnt;
`endif
  logic [3:0] cmds;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  game_cmd_gen #(.DEBOUNCE_CYCLES(4), .LOCKOUT_CYCLES(4), .CNT_W(21)) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_confirm   (btn_confirm),
    .btn_pause     (btn_pause),
    .choose_en     (choose_en),
    .playing_en    (playing_en),
    .pause_en      (pause_en),
    .over_en       (over_en),
    .cmd_continue  (cmd_continue),
    .cmd_pause     (cmd_pause),
    .cmd_esc_pause (cmd_esc_pause),
    .cmd_restart   (cmd_restart)
`ifdef GAME_CMD_CNT_EN
    ,
    .cmd_cnt       (cmd_cnt)
`endif
  );

  assign cmds = {cmd_restart, cmd_esc_pause, cmd_pause, cmd_continue};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Button k-window drives inputs ahead of edge k; outputs checked 1 time unit after edge k.
  task automatic seq(input string tag, input int n, input int c_on, input int c_off,
                     input int p_on, input int p_off, input int e1, input logic [3:0] v1,
                     input int e2, input logic [3:0] v2);
    logic [3:0] exp;
    for (int k = 0; k < n; k++) begin
      btn_confirm = (k >= c_on) && (k < c_off);
      btn_pause   = (k >= p_on) && (k < p_off);
      @(posedge clk);
      #1;
      exp = (k == e1) ? v1 : ((k == e2) ? v2 : 4'b0000);
      check(tag, {28'd0, cmds}, {28'd0, exp});
    end
  endtask

  task automatic release_all(input string tag);
    seq(tag, 14, NO, NO, NO, NO, NO, 4'b0, NO, 4'b0);
  endtask

  initial begin
    rst = 1'b1;
    btn_confirm = 1'b0; btn_pause = 1'b0;
    choose_en = 1'b0; playing_en = 1'b0; pause_en = 1'b0; over_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_cmds", {28'd0, cmds}, 32'd0);
    rst = 1'b0;

    choose_en = 1'b1;
    seq("t1_continue", 20, 0, 20, NO, NO, 6, 4'b0001, NO, 4'b0);
    release_all("t1_release");

    choose_en = 1'b0; playing_en = 1'b1;
    seq("t2_glitch", 12, NO, NO, 0, 3, NO, 4'b0, NO, 4'b0);
    seq("t2_pause", 10, NO, NO, 0, 10, 6, 4'b0010, NO, 4'b0);
    release_all("t2_release");

    playing_en = 1'b0; pause_en = 1'b1;
    seq("t3_both", 20, 0, 20, 0, 20, 6, 4'b0100, NO, 4'b0);
    release_all("t3_release");

    pause_en = 1'b0; over_en = 1'b1;
    seq("t4_restart", 7, 0, NO, 4, NO, 6, 4'b1000, NO, 4'b0);
    over_en = 1'b0; pause_en = 1'b1;
    seq("t4_lock_drop", 13, 0, NO, 0, NO, NO, 4'b0, NO, 4'b0);
    release_all("t4_release_a");

    seq("t4_lock_edge", 20, 0, NO, 5, NO, 6, 4'b0100, 11, 4'b0100);
    release_all("t4_release_b");

    pause_en = 1'b0; choose_en = 1'b1;
    seq("t4_after_lock", 12, 0, NO, NO, NO, 6, 4'b0001, NO, 4'b0);
    release_all("t4_release_c");

    playing_en = 1'b1;
    seq("t5_illegal_en", 20, 0, NO, 0, NO, NO, 4'b0, NO, 4'b0);
    release_all("t5_release");
    playing_en = 1'b0;

    seq("t6_pre_reset", 7, 0, NO, NO, NO, 6, 4'b0001, NO, 4'b0);
    rst = 1'b1;
    #1;
    check("t6_async_reset", {28'd0, cmds}, 32'd0);
    seq("t6_mid_reset", 2, 0, NO, NO, NO, NO, 4'b0, NO, 4'b0);
    rst = 1'b0;
    seq("t6_restart", 12, 0, NO, NO, NO, 6, 4'b0001, NO, 4'b0);
    release_all("t6_release");

`ifdef GAME_CMD_CNT_EN
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("cnt_reset", {24'd0, cmd_cnt}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 257; i++) begin
      seq("cnt_loop", 12, 0, 6, NO, NO, 6, 4'b0001, NO, 4'b0);
    end
    release_all("cnt_release");
    check("cnt_wrap", {24'd0, cmd_cnt}, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
